exe_issuer: RTL and testbench

- Issue and writeback controller that drives the execution-controller interface from the requesting side.
- Owns a SIZE x WIDTH register file and accepts instructions over a valid/ready handshake.
- Per instruction: reads both source operands, presents operands, opcode and destination address to the execution controller, holds enable until ready, then writes the returned result back at the returned destination address.
- Also exposes a host write/read port for loading and inspecting registers.

---
 rtl/exe_issuer.sv | 172 +++++++++++++++++
 tb/tb_exe_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_issuer.sv
// Issue/writeback controller with local register file and host port.
// Optional WAIT timeout enabled by defining EXE_ISSUER_TIMEOUT_EN.
module exe_issuer #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 64,
  parameter int TIMEOUT = 255,
  localparam int AW     = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [AW-1:0]    in_dst,
  input  logic [AW-1:0]    in_src1,
  input  logic [AW-1:0]    in_src2,
  output logic             ex_enable,
  output logic [1:0]       ex_opcode,
  output logic [AW-1:0]    ex_dst_addr,
  output logic [WIDTH-1:0] ex_src1,
  output logic [WIDTH-1:0] ex_src2,
  input  logic             ex_ready,
  input  logic [WIDTH-1:0] ex_result,
  input  logic [AW-1:0]    ex_dst_out,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             busy,
  output logic [15:0]      retired,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, WB, RETIRE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rf_q [SIZE];
  logic [1:0]       opc_q, opc_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [15:0]      ret_q, ret_d;
  logic             wb_en;

`ifdef EXE_ISSUER_TIMEOUT_EN
  localparam int CW0 = $clog2(TIMEOUT + 1);
  localparam int CW  = (CW0 > 8) ? CW0 : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    dst_d   = dst_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    ret_d   = ret_q;
    wb_en   = 1'b0;
`ifdef EXE_ISSUER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opc_d   = in_opcode;
          dst_d   = in_dst;
          s1_d    = rf_q[in_src1];
          s2_d    = rf_q[in_src2];
          state_d = (in_opcode == 2'b00) ? RETIRE : ISSUE;
        end
      end
      ISSUE: begin
        // ex_ready may be left over from the previous op; ignore it here
        state_d = WAIT;
`ifdef EXE_ISSUER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (ex_ready) begin
          wb_en   = 1'b1;
          state_d = WB;
        end
`ifdef EXE_ISSUER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = WB;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      WB: begin
        state_d = RETIRE;
      end
      RETIRE: begin
        ret_d   = ret_q + 16'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      dst_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      dst_q   <= dst_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      ret_q   <= ret_d;
    end
  end

  // Writeback is applied last so it overrides a same-address host write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (host_we) begin
        rf_q[host_addr] <= host_wdata;
      end
      if (wb_en) begin
        rf_q[ex_dst_out] <= ex_result;
      end
    end
  end

`ifdef EXE_ISSUER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ex_enable   = (state_q == ISSUE) || (state_q == WAIT);
  assign ex_opcode   = opc_q;
  assign ex_dst_addr = dst_q;
  assign ex_src1     = s1_q;
  assign ex_src2     = s2_q;
  assign host_rdata  = rf_q[host_addr];
  assign retired     = ret_q;

endmodule

// File: tb/tb_exe_issuer.sv
// Self-checking bench for exe_issuer: vector table, scoreboard, corner cases.
// Timeout path exercised when EXE_ISSUER_TIMEOUT_EN is defined.
module tb_exe_issuer;

  localparam int WIDTH = 8;
  localparam int SIZE  = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [AW-1:0]    in_dst;
  logic [AW-1:0]    in_src1;
  logic [AW-1:0]    in_src2;
  logic             ex_enable;
  logic [1:0]       ex_opcode;
  logic [AW-1:0]    ex_dst_addr;
  logic [WIDTH-1:0] ex_src1;
  logic [WIDTH-1:0] ex_src2;
  logic             ex_ready;
  logic [WIDTH-1:0] ex_result;
  logic [AW-1:0]    ex_dst_out;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;
  logic             busy;
  logic [15:0]      retired;
  logic             err;

  exe_issuer #(
    .WIDTH(WIDTH), .SIZE(SIZE), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dst(in_dst),
    .in_src1(in_src1), .in_src2(in_src2),
    .ex_enable(ex_enable), .ex_opcode(ex_opcode),
    .ex_dst_addr(ex_dst_addr),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_dst_out(ex_dst_out),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] dst;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    int            lat;
    logic [7:0]    e1;
    logic [7:0]    e2;
    logic [7:0]    res;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[6];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_ret = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic host_wr(logic [AW-1:0] a, logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic sb_check(string name);
    sb_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      host_addr = e.addr;
      #1;
      if (host_rdata === e.data) n_pass++;
      else $display("FAIL %s: r%0d got %0h expected %0h",
                    name, e.addr, host_rdata, e.data);
    end
  endtask

  task automatic accept(logic [1:0] op, logic [AW-1:0] d,
                        logic [AW-1:0] a, logic [AW-1:0] b);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_opcode = op;
    in_dst = d; in_src1 = a; in_src2 = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(vec_t v);
    accept(v.op, v.dst, v.s1, v.s2);
    sb.push_back('{v.dst, v.res});
    if (v.op != 2'b00) begin
      chk("issue_enable", ex_enable, 1);
      chk("issue_src1", ex_src1, v.e1);
      chk("issue_src2", ex_src2, v.e2);
      chk("issue_opcode", ex_opcode, v.op);
      chk("issue_dst", ex_dst_addr, v.dst);
      for (int i = 0; i < v.lat; i++) begin
        @(negedge clk);
        chk("wait_enable", ex_enable, 1);
      end
      @(negedge clk);
      ex_ready = 1'b1; ex_result = v.res; ex_dst_out = v.dst;
      @(negedge clk);
      ex_ready = 1'b0;
      chk("wb_enable", ex_enable, 0);
      chk("wb_busy", busy, 1);
      @(negedge clk);
    end else begin
      chk("nop_enable", ex_enable, 0);
      chk("nop_busy", busy, 1);
    end
    @(negedge clk);
    exp_ret++;
    chk("ready_after", in_ready, 1);
    chk("retired", retired, exp_ret);
    sb_check("regfile_wb");
  endtask

  initial begin
    tbl[0] = '{2'b10, 6'd4, 6'd1, 6'd2, 2, 8'd5, 8'd3, 8'd8};
    tbl[1] = '{2'b00, 6'd6, 6'd1, 6'd2, 0, 8'd0, 8'd0, 8'd0};
    tbl[2] = '{2'b11, 6'd4, 6'd1, 6'd2, 1, 8'd5, 8'd3, 8'd2};
    tbl[3] = '{2'b01, 6'd5, 6'd4, 6'd2, 0, 8'd2, 8'd3, 8'd6};
    tbl[4] = '{2'b10, 6'd1, 6'd1, 6'd1, 1, 8'd5, 8'd5, 8'd10};
    tbl[5] = '{2'b11, 6'd7, 6'd5, 6'd1, 3, 8'd6, 8'd10, 8'hFC};

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0;
    in_dst = '0; in_src1 = '0; in_src2 = '0;
    ex_ready = 1'b0; ex_result = '0; ex_dst_out = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_addr = 6'd7;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enable", ex_enable, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", err, 0);
    chk("rst_src1", ex_src1, 0);
    chk("rst_opcode", ex_opcode, 0);
    chk("rst_rf", host_rdata, 0);

    host_wr(6'd1, 8'd5);
    host_wr(6'd2, 8'd3);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Host write in WAIT to another reg, then same-address collision
    accept(2'b10, 6'd4, 6'd1, 6'd2);
    chk("col_src1", ex_src1, 8'd10);
    chk("col_src2", ex_src2, 8'd3);
    @(negedge clk);
    host_we = 1'b1; host_addr = 6'd9; host_wdata = 8'h5A;
    @(negedge clk);
    host_addr = 6'd4; host_wdata = 8'hAA;
    ex_ready = 1'b1; ex_result = 8'h11; ex_dst_out = 6'd4;
    @(negedge clk);
    host_we = 1'b0; ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_ret++;
    chk("col_retired", retired, exp_ret);
    sb.push_back('{6'd4, 8'h11});
    sb_check("col_wb_wins");
    sb.push_back('{6'd9, 8'h5A});
    sb_check("col_host_busy");

    // WAIT with ex_ready held low
    accept(2'b10, 6'd8, 6'd1, 6'd2);
`ifdef EXE_ISSUER_TIMEOUT_EN
    repeat (10) @(negedge clk);
    chk("to_enable_pre", ex_enable, 1);
    chk("to_err_pre", err, 0);
    @(negedge clk);
    chk("to_enable_post", ex_enable, 0);
    chk("to_err_post", err, 1);
    repeat (2) @(negedge clk);
    exp_ret++;
    chk("to_ready", in_ready, 1);
    chk("to_retired", retired, exp_ret);
    sb.push_back('{6'd8, 8'd0});
    sb_check("to_no_wb");
`else
    repeat (20) @(negedge clk);
    chk("hold_enable", ex_enable, 1);
    chk("hold_err", err, 0);
    ex_ready = 1'b1; ex_result = 8'h33; ex_dst_out = 6'd8;
    @(negedge clk);
    ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_ret++;
    chk("hold_retired", retired, exp_ret);
    sb.push_back('{6'd8, 8'h33});
    sb_check("hold_wb");
`endif

    // Asynchronous reset during WAIT
    accept(2'b10, 6'd3, 6'd1, 6'd2);
    @(negedge clk);
    chk("pre_rst_enable", ex_enable, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_enable", ex_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_retired", retired, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1; ex_result = 8'h77; ex_dst_out = 6'd3;
    @(negedge clk);
    ex_ready = 1'b0;
    chk("arst_ready", in_ready, 1);
    sb.push_back('{6'd3, 8'd0});
    sb_check("arst_no_wb");
    sb.push_back('{6'd1, 8'd0});
    sb_check("arst_rf_clr");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
